// File: rtl/data_bus_arbiter_if.sv
// Request/response bus bundle shared by the masters and the downstream port.
// N lanes are packed side by side; lane i of a field lives at [i*W +: W].
interface data_bus_arbiter_if #(
    parameter int N   = 1,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BEW = 4
) ();
    logic [N-1:0]     req;
    logic [N*AW-1:0]  addr;
    logic [N-1:0]     we;
    logic [N*BEW-1:0] be;
    logic [N*DW-1:0]  wdata;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rvalid;
    logic [N-1:0]     err;
    logic [N*DW-1:0]  rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one downstream data bus between NMST masters;
// an in-order FIFO of granted master IDs steers each response back to its issuer.
module data_bus_arbiter #(
    parameter int NMST    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BEW     = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_bus_arbiter_if.slave    mst,
    data_bus_arbiter_if.master   slv,
    output logic                 spurious_rsp
);
    localparam int IDW = (NMST > 1) ? $clog2(NMST) : 1;
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    lock_state_e      state_q, state_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             spurious_q, spurious_d;
    logic [IDW-1:0]   fifo_mem_q [MAX_OUT];

    logic [IDW-1:0]   sel_id;
    logic             sel_valid;
    logic [IDW-1:0]   head_id;
    logic             fifo_full;
    logic             fwd_req;
    logic             hs;
    logic             pop;
    int               idx;

    // While locked the pending address phase must not move to another master.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        idx       = 0;
        if (state_q == LOCKED) begin
            sel_valid = 1'b1;
            sel_id    = lock_id_q;
        end else begin
            for (int k = NMST - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NMST) idx = idx - NMST;
                if (mst.req[idx]) begin
                    sel_valid = 1'b1;
                    sel_id    = IDW'(idx);
                end
            end
        end
    end

    assign fifo_full = (count_q == CW'(MAX_OUT));
    assign fwd_req   = rst & sel_valid & mst.req[sel_id] & ~fifo_full;
    assign hs        = fwd_req & slv.gnt[0];
    assign pop       = rst & slv.rvalid[0] & (count_q != '0);
    assign head_id   = fifo_mem_q[rd_ptr_q];

    always_comb begin
        slv.req   = fwd_req;
        slv.addr  = '0;
        slv.we    = '0;
        slv.be    = '0;
        slv.wdata = '0;
        if (fwd_req) begin
            slv.addr  = mst.addr[sel_id*AW +: AW];
            slv.we    = mst.we[sel_id];
            slv.be    = mst.be[sel_id*BEW +: BEW];
            slv.wdata = mst.wdata[sel_id*DW +: DW];
        end
    end

    always_comb begin
        mst.gnt    = '0;
        mst.rvalid = '0;
        mst.err    = '0;
        mst.rdata  = '0;
        if (hs) mst.gnt[sel_id] = 1'b1;
        if (pop) begin
            mst.rvalid[head_id]             = 1'b1;
            mst.err[head_id]                = slv.err[0];
            mst.rdata[head_id*DW +: DW]     = slv.rdata;
        end
    end

    assign spurious_rsp = rst & spurious_q;

    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        spurious_d = spurious_q | (slv.rvalid[0] & (count_q == '0));

        case (state_q)
            UNLOCKED: begin
                if (fwd_req && !slv.gnt[0]) begin
                    state_d   = LOCKED;
                    lock_id_d = sel_id;
                end
            end
            LOCKED: begin
                // A master that abandons its request must not hold the bus forever.
                if (hs || !mst.req[lock_id_q]) state_d = UNLOCKED;
            end
            default: state_d = UNLOCKED;
        endcase

        if (hs) begin
            rr_ptr_d = (sel_id == IDW'(NMST - 1)) ? '0 : sel_id + 1'b1;
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({hs, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= UNLOCKED;
            lock_id_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (hs) fifo_mem_q[wr_ptr_q] <= sel_id;
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: round-robin order, lock, FIFO limits,
// response routing, spurious responses and asynchronous reset.
module tb_data_bus_arbiter;
    localparam int NMST    = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BEW     = 4;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spurious_rsp;

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.N(NMST), .AW(AW), .DW(DW), .BEW(BEW)) mst_if ();
    data_bus_arbiter_if #(.N(1),    .AW(AW), .DW(DW), .BEW(BEW)) slv_if ();

    data_bus_arbiter #(
        .NMST(NMST), .AW(AW), .DW(DW), .BEW(BEW), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mst          (mst_if),
        .slv          (slv_if),
        .spurious_rsp (spurious_rsp)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] rd_tab [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs; checks follow at posedge+3.
    task automatic cyc(input logic [1:0] req, input logic g, input logic rv,
                       input logic er, input logic [31:0] rd);
        @(posedge clk);
        #1;
        mst_if.req   = req;
        slv_if.gnt   = g;
        slv_if.rvalid = rv;
        slv_if.err   = er;
        slv_if.rdata = rd;
        #2;
    endtask

    initial begin
        rd_tab = '{32'hA0, 32'hB1, 32'hA2, 32'hB3};
        mst_if.req    = '0;
        mst_if.addr   = {32'h0000_0200, 32'h0000_0100};
        mst_if.we     = '0;
        mst_if.be     = {4'hF, 4'h3};
        mst_if.wdata  = {32'h0000_B0B0, 32'h0000_A0A0};
        slv_if.gnt    = '0;
        slv_if.rvalid = '0;
        slv_if.err    = '0;
        slv_if.rdata  = '0;

        // Reset and idle
        cyc(2'b00, 0, 0, 0, 0);
        check("rst_slv_req", 64'(slv_if.req), 64'(0));
        check("rst_gnt", 64'(mst_if.gnt), 64'(0));
        check("rst_spurious", 64'(spurious_rsp), 64'(0));
        #1 rst = 1'b1;
        cyc(2'b00, 0, 0, 0, 0);
        check("idle_slv_req", 64'(slv_if.req), 64'(0));
        check("idle_addr", 64'(slv_if.addr), 64'(0));
        check("idle_gnt", 64'(mst_if.gnt), 64'(0));

        // Round robin with both masters requesting, responses one cycle later
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 1, (k > 0), 0, rd_tab[(k == 0) ? 0 : k - 1]);
            check("rr_gnt", 64'(mst_if.gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("rr_addr", 64'(slv_if.addr), (k % 2 == 0) ? 64'h100 : 64'h200);
            if (k > 0) begin
                check("rr_rvalid", 64'(mst_if.rvalid), ((k - 1) % 2 == 0) ? 64'h1 : 64'h2);
                check("rr_rdata", 64'(mst_if.rdata[((k - 1) % 2) * DW +: DW]), 64'(rd_tab[k - 1]));
            end
        end
        cyc(2'b00, 0, 1, 0, rd_tab[3]);
        check("rr_last_rvalid", 64'(mst_if.rvalid), 64'h2);
        check("rr_last_rdata", 64'(mst_if.rdata[DW +: DW]), 64'hB3);
        check("rr_last_gnt", 64'(mst_if.gnt), 64'h0);

        // Lock: master 1 waits three cycles, master 0 joins in cycle 2
        cyc(2'b10, 0, 0, 0, 0);
        check("lk1_req", 64'(slv_if.req), 64'h1);
        check("lk1_addr", 64'(slv_if.addr), 64'h200);
        check("lk1_gnt", 64'(mst_if.gnt), 64'h0);
        cyc(2'b11, 0, 0, 0, 0);
        check("lk2_addr", 64'(slv_if.addr), 64'h200);
        cyc(2'b11, 0, 0, 0, 0);
        check("lk3_addr", 64'(slv_if.addr), 64'h200);
        cyc(2'b11, 1, 0, 0, 0);
        check("lk4_gnt", 64'(mst_if.gnt), 64'h2);
        check("lk4_addr", 64'(slv_if.addr), 64'h200);
        cyc(2'b01, 1, 0, 0, 0);
        check("lk5_gnt", 64'(mst_if.gnt), 64'h1);
        check("lk5_addr", 64'(slv_if.addr), 64'h100);

        // Outstanding limit: two in flight
        cyc(2'b01, 1, 0, 0, 0);
        check("full_req", 64'(slv_if.req), 64'h0);
        check("full_gnt", 64'(mst_if.gnt), 64'h0);
        check("full_addr", 64'(slv_if.addr), 64'h0);
        cyc(2'b01, 1, 1, 0, 32'h11);
        check("full_pop_req", 64'(slv_if.req), 64'h0);
        check("full_pop_rvalid", 64'(mst_if.rvalid), 64'h2);
        check("full_pop_rdata", 64'(mst_if.rdata[DW +: DW]), 64'h11);
        cyc(2'b01, 1, 1, 0, 32'h22);
        check("unblk_req", 64'(slv_if.req), 64'h1);
        check("unblk_gnt", 64'(mst_if.gnt), 64'h1);
        check("unblk_rvalid", 64'(mst_if.rvalid), 64'h1);
        check("unblk_rdata", 64'(mst_if.rdata[0 +: DW]), 64'h22);
        cyc(2'b01, 1, 0, 0, 0);
        check("pushpop_gnt", 64'(mst_if.gnt), 64'h1);
        cyc(2'b01, 1, 0, 0, 0);
        check("refull_req", 64'(slv_if.req), 64'h0);
        cyc(2'b00, 0, 1, 0, 32'h33);
        check("drain1_rvalid", 64'(mst_if.rvalid), 64'h1);
        cyc(2'b00, 0, 1, 0, 32'h44);
        check("drain2_rvalid", 64'(mst_if.rvalid), 64'h1);
        check("drain2_rdata", 64'(mst_if.rdata[0 +: DW]), 64'h44);

        // Write from master 1, read from master 0, error then data
        mst_if.we    = 2'b10;
        mst_if.wdata = {32'h0000_0055, 32'h0000_A0A0};
        cyc(2'b10, 1, 0, 0, 0);
        check("wr_gnt", 64'(mst_if.gnt), 64'h2);
        check("wr_we", 64'(slv_if.we), 64'h1);
        check("wr_wdata", 64'(slv_if.wdata), 64'h55);
        check("wr_be", 64'(slv_if.be), 64'hF);
        mst_if.we = 2'b00;
        cyc(2'b01, 1, 0, 0, 0);
        check("rd_gnt", 64'(mst_if.gnt), 64'h1);
        check("rd_we", 64'(slv_if.we), 64'h0);
        check("rd_be", 64'(slv_if.be), 64'h3);
        cyc(2'b00, 0, 1, 1, 0);
        check("err_rvalid", 64'(mst_if.rvalid), 64'h2);
        check("err_err", 64'(mst_if.err), 64'h2);
        cyc(2'b00, 0, 1, 0, 32'hDEADBEEF);
        check("data_rvalid", 64'(mst_if.rvalid), 64'h1);
        check("data_err", 64'(mst_if.err), 64'h0);
        check("data_rdata", 64'(mst_if.rdata[0 +: DW]), 64'hDEADBEEF);

        // Spurious response with nothing outstanding
        cyc(2'b00, 0, 1, 0, 32'h77);
        check("spur_rvalid", 64'(mst_if.rvalid), 64'h0);
        cyc(2'b00, 0, 0, 0, 0);
        check("spur_set", 64'(spurious_rsp), 64'h1);
        cyc(2'b00, 0, 0, 0, 0);
        check("spur_sticky", 64'(spurious_rsp), 64'h1);

        // Asynchronous reset in the middle of a transaction
        cyc(2'b01, 1, 0, 0, 0);
        check("pre_rst_gnt", 64'(mst_if.gnt), 64'h1);
        cyc(2'b01, 0, 0, 0, 0);
        check("pre_rst_req", 64'(slv_if.req), 64'h1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_req", 64'(slv_if.req), 64'h0);
        check("async_rst_addr", 64'(slv_if.addr), 64'h0);
        check("async_rst_spur", 64'(spurious_rsp), 64'h0);
        cyc(2'b00, 0, 0, 0, 0);
        #1 rst = 1'b1;
        cyc(2'b00, 0, 1, 0, 32'h99);
        check("post_rst_rvalid", 64'(mst_if.rvalid), 64'h0);
        cyc(2'b00, 0, 0, 0, 0);
        check("post_rst_spur", 64'(spurious_rsp), 64'h1);
        cyc(2'b01, 1, 0, 0, 0);
        check("post_rst_gnt1", 64'(mst_if.gnt), 64'h1);
        cyc(2'b01, 1, 0, 0, 0);
        check("post_rst_gnt2", 64'(mst_if.gnt), 64'h1);
        cyc(2'b01, 1, 0, 0, 0);
        check("post_rst_full", 64'(slv_if.req), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Round-robin arbiter that shares one downstream DATA_BUS port between NMST upstream masters.
- It sits between the masters and the address decoder / slave demux, replacing the fixed "master 0 only" selection.
- It keeps an in-order FIFO of granted master IDs, so each read/write response (rvalid/err/rdata) returns to the master that issued it.
- Up to MAX_OUT transactions may be outstanding.

Parameters:
- NMST, 2, number of upstream masters (>=2)
- AW, 32, address width
- DW, 32, data width
- BEW, 4, byte-enable width
- MAX_OUT, 2, maximum outstanding (granted, not yet responded) transactions; power of two, >=1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- mst_req  in  NMST  per-master request
- mst_addr  in  NMST*AW  per-master address, master i at [i*AW +: AW]
- mst_we  in  NMST  per-master write enable
- mst_be  in  NMST*BEW  per-master byte enables
- mst_wdata  in  NMST*DW  per-master write data
- mst_gnt  out  NMST  per-master grant
- mst_rvalid  out  NMST  per-master response valid
- mst_err  out  NMST  per-master response error
- mst_rdata  out  NMST*DW  per-master read data
- slv_req  out  1  downstream request
- slv_addr  out  AW  downstream address
- slv_we  out  1  downstream write enable
- slv_be  out  BEW  downstream byte enables
- slv_wdata  out  DW  downstream write data
- slv_gnt  in  1  downstream grant
- slv_rvalid  in  1  downstream response valid
- slv_err  in  1  downstream response error
- slv_rdata  in  DW  downstream read data
- spurious_rsp  out  1  sticky flag: slv_rvalid arrived while no transaction was outstanding

Behaviour:
- Protocol:
  - Address phase completes in the cycle where req and gnt are both 1.
  - Response is the single cycle with rvalid=1, at least 1 cycle after its gnt.
  - Responses return in order.
  - A master holds req/addr/we/be/wdata stable until it is granted.
- Reset (rst=0, asynchronous):
  - rr_ptr=0, lock cleared, ID FIFO emptied (count=0), spurious_rsp=0.
  - All outputs become 0 immediately.
  - Responses arriving after reset for pre-reset transactions count as spurious.
- Selection:
  - If lock is set, sel = locked master.
  - Otherwise sel = first master with mst_req=1, searching upward from rr_ptr with wrap-around (NMST-1 wraps to 0).
  - No request means no selection.
- Forwarding (combinational, 0-cycle latency):
  - slv_req = mst_req[sel] & (count<MAX_OUT), with sel's addr/we/be/wdata on the downstream bus.
  - When slv_req=0, the downstream address/data outputs are 0.
  - mst_gnt[sel] = slv_gnt & slv_req; all other mst_gnt bits are 0.
- Lock FSM, two states:
  - UNLOCKED -> LOCKED(sel) when slv_req=1 and slv_gnt=0. No re-arbitration while a request is pending, so the downstream address phase stays stable.
  - LOCKED -> UNLOCKED on the handshake.
  - If the locked master drops req without a grant (protocol violation), the lock clears on the next cycle.
- On each handshake:
  - Push sel into the ID FIFO.
  - rr_ptr <= (sel+1) mod NMST.
  - A back-to-back handshake from a different master is allowed in the next cycle.
- Responses:
  - When slv_rvalid=1 and count>0, route rvalid/err/rdata to master fifo_head and pop.
  - Non-head masters see rvalid=0, err=0, rdata=0.
- Boundaries:
  - Push and pop in the same cycle leave count unchanged (legal, including when full).
  - At count=MAX_OUT, slv_req is held at 0 and nobody is granted. A pop in the same cycle does not unblock; the next cycle does.
  - slv_rvalid with count=0: no mst_rvalid is raised and spurious_rsp is set to 1 until reset.
  - FIFO pointers wrap modulo MAX_OUT.
  - With NMST requests continuously active, each master is granted exactly once per NMST handshakes.

Test Plan:
- Reset then idle, all mst_req=0 -> slv_req=0, all mst_gnt=0, spurious_rsp=0; assert rst=0 mid-transaction -> outputs 0 in the same cycle, count=0.
- Masters 0 and 1 both request continuously, slv_gnt=1 always, responses 1 cycle later -> grant order 0,1,0,1; responses return to 0,1,0,1 with rdata values 0xA0,0xB1,… matching.
- Master 1 alone requests, slv_gnt held 0 for 3 cycles; master 0 raises req in cycle 2 -> slv_addr stays master 1's address for all cycles, master 1 is granted in cycle 4, master 0 in cycle 5.
- MAX_OUT=2, two grants with no rvalid -> third request sees slv_req=0; rvalid in cycle N -> slv_req=1 in cycle N+1; same-cycle gnt+rvalid at count=1 leaves count=1.
- Master 1 write granted, then master 0 read granted; rvalid with err=1, then rvalid with rdata=0xDEADBEEF -> mst_err[1]=1, then mst_rvalid[0]=1 with mst_rdata[0]=0xDEADBEEF.
- slv_rvalid pulse with count=0 -> no mst_rvalid, spurious_rsp=1 and it stays 1 until rst.
